// File: rtl/score_tally.sv
// -----------------------------------------------------------------------------
// score_tally
//   Collects the hit and miss events from all arrow droppers. Keeps the game
//   score, the current combo and the best combo. Converts the score to 4-digit
//   BCD for the score display. Runs on the 50 MHz system clock. The dropper
//   levels come from the slow frame_clk domain, so this block synchronises
//   them.
//
//   Optional feature macro: SCORE_TALLY_COMBO_MULT_EN
//     defined   -> a hit scores PTS_PER_HIT * (1 + min(combo/COMBO_STEP, MULT_MAX-1))
//     undefined -> every hit scores PTS_PER_HIT
//
// Ports
//   Clk        in   system clock
//   Reset_n    in   asynchronous active-low reset
//   keycode    in   primary USB keycode (2C start, 29 stop, 01 back to idle)
//   hit        in   per-lane score level from droppers, rising edge = hit
//   miss       in   per-lane finish-without-score level, rising edge = miss
//   score      out  binary score, saturates at SCORE_MAX
//   combo      out  current consecutive-hit count, saturates at 999
//   max_combo  out  best combo this game
//   score_bcd  out  4 BCD digits of score, thousands in [15:12]
//   running    out  high while a game is in progress (RUN state)
// -----------------------------------------------------------------------------
module score_tally #(
   parameter int N_LANES     = 40,
   parameter int PTS_PER_HIT = 10,
   parameter int COMBO_STEP  = 10,
   parameter int MULT_MAX    = 4,
   parameter int SCORE_MAX   = 9999
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic [7:0]         keycode,
   input  logic [N_LANES-1:0] hit,
   input  logic [N_LANES-1:0] miss,
   output logic [13:0]        score,
   output logic [9:0]         combo,
   output logic [9:0]         max_combo,
   output logic [15:0]        score_bcd,
   output logic               running
);

`ifdef SCORE_TALLY_COMBO_MULT_EN
   localparam bit MULT_EN = 1'b1;
`else
   localparam bit MULT_EN = 1'b0;
`endif

   localparam int         IDX_W     = (N_LANES > 1) ? $clog2(N_LANES) : 1;
   localparam logic [9:0] COMBO_CAP = 10'd999;
   localparam logic [7:0] KEY_START = 8'h2C;
   localparam logic [7:0] KEY_STOP  = 8'h29;
   localparam logic [7:0] KEY_IDLE  = 8'h01;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state, state_next;
   logic               start_game;

   logic [N_LANES-1:0] hit_meta, hit_sync, hit_prev, hit_rise;
   logic [N_LANES-1:0] miss_meta, miss_sync, miss_prev, miss_rise;
   logic [N_LANES-1:0] pend_hit, pend_miss, pend_hit_next, pend_miss_next;
   logic [N_LANES-1:0] clr_hit, clr_miss;

   logic [IDX_W-1:0]   scan_idx, scan_idx_next;
   logic               apply_hit, apply_miss;

   logic [9:0]         step_cnt;
   logic [2:0]         mult;
   logic [15:0]        pts, sum_w;
   logic [13:0]        score_hit;
   logic [9:0]         combo_hit;

   // ---------------------------------------------------------------------------
   // Input capture: 2-flop synchroniser, then one flop for edge detection.
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge value of its neighbours; blocking here would collapse the chain.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         hit_meta  <= '0;
         hit_sync  <= '0;
         hit_prev  <= '0;
         miss_meta <= '0;
         miss_sync <= '0;
         miss_prev <= '0;
      end else begin
         hit_meta  <= hit;
         hit_sync  <= hit_meta;
         hit_prev  <= hit_sync;
         miss_meta <= miss;
         miss_sync <= miss_meta;
         miss_prev <= miss_sync;
      end
   end

   assign hit_rise  = hit_sync  & ~hit_prev;
   assign miss_rise = miss_sync & ~miss_prev;

   // ---------------------------------------------------------------------------
   // Game FSM
   // ---------------------------------------------------------------------------
   // NOTE: every always_comb output gets a default first; a path that leaves
   // one unassigned would infer a latch.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (keycode == KEY_START) state_next = RUN;
         RUN:     if (keycode == KEY_STOP)  state_next = DONE;
                  else if (keycode == KEY_IDLE) state_next = IDLE;
         DONE:    if (keycode == KEY_IDLE)  state_next = IDLE;
                  else if (keycode == KEY_START) state_next = RUN;
         default: state_next = IDLE;
      endcase
   end

   assign start_game = (state_next == RUN) && (state != RUN);
   assign running    = (state == RUN);

   // ---------------------------------------------------------------------------
   // Scanner: one lane per cycle. A hit on the lane also discards its miss.
   // A new edge is ORed in after the clear, so an edge that arrives while its
   // lane is being cleared survives to the next pass.
   // ---------------------------------------------------------------------------
   always_comb begin
      pend_hit_next  = '0;
      pend_miss_next = '0;
      clr_hit        = '0;
      clr_miss       = '0;
      apply_hit      = 1'b0;
      apply_miss     = 1'b0;
      scan_idx_next  = (scan_idx == IDX_W'(N_LANES - 1)) ? '0 : scan_idx + IDX_W'(1);
      if (state == RUN) begin
         if (pend_hit[scan_idx]) begin
            apply_hit          = 1'b1;
            clr_hit[scan_idx]  = 1'b1;
            clr_miss[scan_idx] = 1'b1;
         end else if (pend_miss[scan_idx]) begin
            apply_miss         = 1'b1;
            clr_miss[scan_idx] = 1'b1;
         end
         pend_hit_next  = (pend_hit  & ~clr_hit)  | hit_rise;
         pend_miss_next = (pend_miss & ~clr_miss) | miss_rise;
      end
   end

   // Hit arithmetic. The multiplier comes from the combo value before this hit.
   always_comb begin
      step_cnt = combo / 10'(COMBO_STEP);
      if (!MULT_EN)
         mult = 3'd1;
      else if (step_cnt >= 10'(MULT_MAX - 1))
         mult = 3'(MULT_MAX);
      else
         mult = 3'(step_cnt) + 3'd1;
      pts       = 16'(PTS_PER_HIT) * 16'(mult);
      sum_w     = 16'(score) + pts;
      score_hit = (sum_w > 16'(SCORE_MAX)) ? 14'(SCORE_MAX) : sum_w[13:0];
      combo_hit = (combo >= COMBO_CAP) ? COMBO_CAP : combo + 10'd1;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state     <= IDLE;
         pend_hit  <= '0;
         pend_miss <= '0;
         scan_idx  <= '0;
         score     <= '0;
         combo     <= '0;
         max_combo <= '0;
      end else begin
         state     <= state_next;
         pend_hit  <= pend_hit_next;
         pend_miss <= pend_miss_next;
         if (start_game) begin
            scan_idx  <= '0;
            score     <= '0;
            combo     <= '0;
            max_combo <= '0;
         end else if (state == RUN) begin
            scan_idx <= scan_idx_next;
            if (apply_hit) begin
               score <= score_hit;
               combo <= combo_hit;
               if (combo_hit > max_combo) max_combo <= combo_hit;
            end else if (apply_miss) begin
               combo <= '0;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Binary to BCD: one load cycle, then 14 double-dabble shifts. score_bcd is
   // written only on the last shift, so it never shows a partial value. A score
   // that differs from the last converted value (dirty) starts a new pass as
   // soon as the converter is idle.
   // ---------------------------------------------------------------------------
   logic        bcd_busy;
   logic [3:0]  bit_cnt;
   logic [13:0] bin_sh, conv_src;
   logic [15:0] bcd_sh, bcd_adj, bcd_shift;
   logic        score_dirty;

   always_comb begin
      bcd_adj = bcd_sh;
      for (int d = 0; d < 4; d++) begin
         if (bcd_sh[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_sh[4*d +: 4] + 4'd3;
      end
      bcd_shift = {bcd_adj[14:0], bin_sh[13]};
   end

   assign score_dirty = (score != conv_src);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         bcd_busy  <= 1'b0;
         bit_cnt   <= '0;
         bin_sh    <= '0;
         bcd_sh    <= '0;
         conv_src  <= '0;
         score_bcd <= '0;
      end else if (!bcd_busy) begin
         if (score_dirty) begin
            bcd_busy <= 1'b1;
            bit_cnt  <= 4'd14;
            bin_sh   <= score;
            bcd_sh   <= '0;
            conv_src <= score;
         end
      end else begin
         bcd_sh  <= bcd_shift;
         bin_sh  <= {bin_sh[12:0], 1'b0};
         bit_cnt <= bit_cnt - 4'd1;
         if (bit_cnt == 4'd1) begin
            bcd_busy  <= 1'b0;
            score_bcd <= bcd_shift;
         end
      end
   end

endmodule

// File: tb/tb_score_tally.sv
// -----------------------------------------------------------------------------
// tb_score_tally
//   Directed bench for score_tally with hand-computed expected values. Expected
//   scores follow SCORE_TALLY_COMBO_MULT_EN when the macro is defined.
// -----------------------------------------------------------------------------
module tb_score_tally;
   localparam int N = 40;

`ifdef SCORE_TALLY_COMBO_MULT_EN
   localparam bit MULT_ON = 1'b1;
`else
   localparam bit MULT_ON = 1'b0;
`endif

   logic          Clk;
   logic          Reset_n;
   logic [7:0]    keycode;
   logic [N-1:0]  hit;
   logic [N-1:0]  miss;
   logic [13:0]   score;
   logic [9:0]    combo;
   logic [9:0]    max_combo;
   logic [15:0]   score_bcd;
   logic          running;

   int n_checks = 0;
   int n_fail   = 0;

   score_tally #(
      .N_LANES(N), .PTS_PER_HIT(10), .COMBO_STEP(10), .MULT_MAX(4), .SCORE_MAX(9999)
   ) dut (
      .Clk(Clk), .Reset_n(Reset_n), .keycode(keycode), .hit(hit), .miss(miss),
      .score(score), .combo(combo), .max_combo(max_combo),
      .score_bcd(score_bcd), .running(running)
   );

   initial Clk = 1'b0;
   always #10 Clk = ~Clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1, "watchdog");
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge Clk);
   endtask

   // Keycode is held for one full cycle, set and cleared on falling edges.
   task automatic press_key(input logic [7:0] k);
      @(negedge Clk);
      keycode = k;
      @(negedge Clk);
      keycode = 8'h00;
   endtask

   task automatic new_game();
      press_key(8'h01);
      press_key(8'h2C);
   endtask

   task automatic clear_lanes();
      @(negedge Clk);
      hit  = '0;
      miss = '0;
      wait_cycles(4);
   endtask

   task automatic test_reset();
      Reset_n = 1'b0;
      keycode = 8'h00;
      hit     = '0;
      miss    = '0;
      #25;
      n_checks++; if (score !== 14'd0) begin n_fail++; $display("FAIL reset_score: got %0d want 0", score); end
      n_checks++; if (combo !== 10'd0) begin n_fail++; $display("FAIL reset_combo: got %0d want 0", combo); end
      n_checks++; if (max_combo !== 10'd0) begin n_fail++; $display("FAIL reset_max_combo: got %0d want 0", max_combo); end
      n_checks++; if (score_bcd !== 16'h0000) begin n_fail++; $display("FAIL reset_bcd: got %h want 0000", score_bcd); end
      n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b want 0", running); end
      @(negedge Clk);
      Reset_n = 1'b1;
      wait_cycles(2);
      press_key(8'h2C);
      n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL start_running: got %b want 1", running); end
      n_checks++; if (score !== 14'd0) begin n_fail++; $display("FAIL start_score: got %0d want 0", score); end
      n_checks++; if (score_bcd !== 16'h0000) begin n_fail++; $display("FAIL start_bcd: got %h want 0000", score_bcd); end
   endtask

   task automatic test_single_hit();
      int cyc;
      @(negedge Clk);
      hit[39] = 1'b1;
      cyc = 0;
      while (score === 14'd0 && cyc < 43) begin
         @(posedge Clk); #1; cyc++;
      end
      n_checks++; if (score !== 14'd10) begin n_fail++; $display("FAIL single_score: got %0d want 10 after %0d cycles", score, cyc); end
      n_checks++; if (combo !== 10'd1) begin n_fail++; $display("FAIL single_combo: got %0d want 1", combo); end
      cyc = 0;
      while (score_bcd !== 16'h0010 && cyc < 15) begin
         @(posedge Clk); #1; cyc++;
      end
      n_checks++; if (score_bcd !== 16'h0010) begin n_fail++; $display("FAIL single_bcd: got %h want 0010", score_bcd); end
      wait_cycles(2 * N + 10);
      n_checks++; if (score !== 14'd10) begin n_fail++; $display("FAIL held_level_score: got %0d want 10", score); end
      n_checks++; if (combo !== 10'd1) begin n_fail++; $display("FAIL held_level_combo: got %0d want 1", combo); end
      clear_lanes();
   endtask

   task automatic test_combo();
      logic [13:0] exp_score;
      logic [15:0] exp_bcd;
      exp_score = MULT_ON ? 14'd140 : 14'd120;
      exp_bcd   = MULT_ON ? 16'h0140 : 16'h0120;
      new_game();
      @(negedge Clk);
      hit[11:0] = '1;
      wait_cycles(2 * N + 10);
      n_checks++; if (score !== exp_score) begin n_fail++; $display("FAIL combo_score: got %0d want %0d", score, exp_score); end
      n_checks++; if (combo !== 10'd12) begin n_fail++; $display("FAIL combo_count: got %0d want 12", combo); end
      n_checks++; if (max_combo !== 10'd12) begin n_fail++; $display("FAIL combo_max: got %0d want 12", max_combo); end
      n_checks++; if (score_bcd !== exp_bcd) begin n_fail++; $display("FAIL combo_bcd: got %h want %h", score_bcd, exp_bcd); end
      @(negedge Clk);
      miss[12] = 1'b1;
      wait_cycles(2 * N + 10);
      n_checks++; if (combo !== 10'd0) begin n_fail++; $display("FAIL miss_combo: got %0d want 0", combo); end
      n_checks++; if (max_combo !== 10'd12) begin n_fail++; $display("FAIL miss_max: got %0d want 12", max_combo); end
      n_checks++; if (score !== exp_score) begin n_fail++; $display("FAIL miss_score: got %0d want %0d", score, exp_score); end
      clear_lanes();
   endtask

   task automatic test_simultaneous();
      new_game();
      @(negedge Clk);
      hit[3]  = 1'b1;
      miss[3] = 1'b1;
      hit[5]  = 1'b1;
      wait_cycles(2 * N + 10);
      n_checks++; if (combo !== 10'd2) begin n_fail++; $display("FAIL simul_combo: got %0d want 2", combo); end
      n_checks++; if (score !== 14'd20) begin n_fail++; $display("FAIL simul_score: got %0d want 20", score); end
      n_checks++; if (max_combo !== 10'd2) begin n_fail++; $display("FAIL simul_max: got %0d want 2", max_combo); end
      n_checks++; if (score_bcd !== 16'h0020) begin n_fail++; $display("FAIL simul_bcd: got %h want 0020", score_bcd); end
      clear_lanes();
   endtask

   // The scanner is at lane 0 on the start edge E0 and reaches lane 7 in the
   // cycle before E0+8. A first pulse on lane 7 is pending by then. A second
   // rising edge is timed to show up in the synchroniser in that same cycle,
   // so it collides with the clear and must still be counted on the next pass.
   task automatic test_back_to_back();
      new_game();
      hit[7] = 1'b1;
      @(negedge Clk);
      hit[7] = 1'b0;
      repeat (4) @(negedge Clk);
      hit[7] = 1'b1;
      wait_cycles(2 * N + 10);
      n_checks++; if (combo !== 10'd2) begin n_fail++; $display("FAIL race_combo: got %0d want 2", combo); end
      n_checks++; if (score !== 14'd20) begin n_fail++; $display("FAIL race_score: got %0d want 20", score); end
      clear_lanes();
   endtask

   task automatic test_saturation();
      logic [13:0] exp_round1;
      exp_round1 = MULT_ON ? 14'd1000 : 14'd400;
      new_game();
      for (int r = 0; r < 25; r++) begin
         @(negedge Clk);
         hit = '1;
         wait_cycles(50);
         if (r == 0) begin
            n_checks++; if (combo !== 10'd40) begin n_fail++; $display("FAIL round1_combo: got %0d want 40", combo); end
            n_checks++; if (score !== exp_round1) begin n_fail++; $display("FAIL round1_score: got %0d want %0d", score, exp_round1); end
         end
         @(negedge Clk);
         hit = '0;
         wait_cycles(4);
      end
      wait_cycles(20);
      n_checks++; if (score !== 14'd9999) begin n_fail++; $display("FAIL sat_score: got %0d want 9999", score); end
      n_checks++; if (combo !== 10'd999) begin n_fail++; $display("FAIL sat_combo: got %0d want 999", combo); end
      n_checks++; if (max_combo !== 10'd999) begin n_fail++; $display("FAIL sat_max: got %0d want 999", max_combo); end
      n_checks++; if (score_bcd !== 16'h9999) begin n_fail++; $display("FAIL sat_bcd: got %h want 9999", score_bcd); end
   endtask

   task automatic test_control();
      int cyc;
      new_game();
      @(negedge Clk);
      hit[2] = 1'b1;
      wait_cycles(50);
      n_checks++; if (score !== 14'd10) begin n_fail++; $display("FAIL ctl_first_hit: got %0d want 10", score); end
      press_key(8'h29);
      n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL ctl_done_running: got %b want 0", running); end
      @(negedge Clk);
      hit[3] = 1'b1;
      wait_cycles(50);
      n_checks++; if (score !== 14'd10) begin n_fail++; $display("FAIL ctl_done_frozen: got %0d want 10", score); end
      n_checks++; if (combo !== 10'd1) begin n_fail++; $display("FAIL ctl_done_combo: got %0d want 1", combo); end
      press_key(8'h01);
      n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL ctl_idle_running: got %b want 0", running); end
      n_checks++; if (score !== 14'd10) begin n_fail++; $display("FAIL ctl_idle_score: got %0d want 10", score); end
      wait_cycles(20);
      n_checks++; if (score_bcd !== 16'h0010) begin n_fail++; $display("FAIL ctl_idle_bcd: got %h want 0010", score_bcd); end
      clear_lanes();
      press_key(8'h2C);
      n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL ctl_restart_running: got %b want 1", running); end
      n_checks++; if (score !== 14'd0) begin n_fail++; $display("FAIL ctl_restart_score: got %0d want 0", score); end
      n_checks++; if (max_combo !== 10'd0) begin n_fail++; $display("FAIL ctl_restart_max: got %0d want 0", max_combo); end
      @(negedge Clk);
      hit[4] = 1'b1;
      wait_cycles(60);
      n_checks++; if (score_bcd !== 16'h0010) begin n_fail++; $display("FAIL pre_reset_bcd: got %h want 0010", score_bcd); end
      @(negedge Clk);
      hit[5] = 1'b1;
      cyc = 0;
      while (score === 14'd10 && cyc < 43) begin
         @(posedge Clk); #1; cyc++;
      end
      n_checks++; if (score !== 14'd20) begin n_fail++; $display("FAIL pre_reset_score: got %0d want 20", score); end
      repeat (5) @(posedge Clk);
      #1;
      Reset_n = 1'b0;
      #1;
      n_checks++; if (score_bcd !== 16'h0000) begin n_fail++; $display("FAIL midconv_reset_bcd: got %h want 0000", score_bcd); end
      n_checks++; if (score !== 14'd0) begin n_fail++; $display("FAIL midconv_reset_score: got %0d want 0", score); end
      n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL midconv_reset_running: got %b want 0", running); end
      hit = '0;
      wait_cycles(2);
      Reset_n = 1'b1;
      wait_cycles(2);
   endtask

   initial begin
      test_reset();
      test_single_hit();
      test_combo();
      test_simultaneous();
      test_back_to_back();
      test_saturation();
      test_control();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/score_tally.md
Name: score_tally

Overview:
- Consumer end of the per-lane dropper hit/miss interface: collects hit and miss events from all arrow droppers and keeps the game score, current combo and best combo.
- Converts the score to 4-digit BCD for the hex/VGA score display.
- Runs on the 50 MHz system clock. Dropper outputs are slow frame_clk-domain levels and are synchronised inside this block.

Parameters:
- N_LANES, 40, number of dropper hit/miss input pairs
- PTS_PER_HIT, 10, base points per hit
- COMBO_STEP, 10, consecutive hits per multiplier increment
- MULT_MAX, 4, multiplier ceiling
- SCORE_MAX, 9999, score saturation value (fits 14 bits)

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous active-low reset
- keycode  in  8  primary USB keycode
- hit  in  N_LANES  per-lane score level from droppers (0->1 = hit)
- miss  in  N_LANES  per-lane finish-without-score level (0->1 = miss)
- score  out  14  binary score
- combo  out  10  current consecutive-hit count
- max_combo  out  10  best combo this game
- score_bcd  out  16  4 BCD digits of score, thousands in [15:12]
- running  out  1  high in RUN state

Behaviour:
- Reset (async, Reset_n=0): state IDLE, all outputs 0, pending vectors 0, scan index 0, sync/edge flops 0.
- Input capture:
  - hit and miss go through a 2-flop synchroniser, then a 1-flop edge detector.
  - A rising edge sets pend_hit[i] / pend_miss[i].
  - Set wins over a same-cycle clear by the scanner, so no event is lost.
  - Edges are captured only in RUN; in IDLE/DONE the pending vectors are held at 0.
- FSM:
  - IDLE: keycode==8'h2C -> RUN. On entry to RUN: score, combo, max_combo and pending vectors cleared; scan index 0.
  - RUN: keycode==8'h29 -> DONE (score frozen); keycode==8'h01 -> IDLE.
  - DONE: keycode==8'h01 -> IDLE; keycode==8'h2C -> RUN (fresh game).
  - IDLE keeps the last score/score_bcd visible. running=1 only in RUN.
- Scanner (RUN only):
  - Index i steps 0..N_LANES-1 and wraps, one lane per Clk. Full pass = N_LANES cycles.
  - At lane i, pend_hit[i] set: apply hit and clear both pend_hit[i] and pend_miss[i]. Hit wins; a same-lane miss is discarded.
  - Else pend_miss[i] set: apply miss and clear pend_miss[i].
  - At most one event is applied per cycle.
- Hit:
  - mult = 1 + min(combo/COMBO_STEP, MULT_MAX-1), using combo before the increment.
  - score = min(score + PTS_PER_HIT*mult, SCORE_MAX).
  - combo = min(combo+1, 999).
  - max_combo = max(max_combo, new combo).
  - All three update in the same cycle.
- Miss: combo=0. score and max_combo unchanged.
- Event latency: synchroniser input edge to counter update is 3 to N_LANES+3 Clk cycles.
- BCD converter:
  - Sequential double-dabble, 14 shift cycles plus 1 load cycle.
  - Starts when score differs from last converted value and the converter is idle.
  - score_bcd updates atomically when a conversion finishes; no partial values are visible.
  - A score change mid-conversion sets dirty; a new conversion starts right after the current one.
  - Steady-state latency from score change to score_bcd: 15 cycles.
- Reset mid-conversion or mid-scan: everything returns to reset values immediately.

Optional Feature:
- SCORE_TALLY_COMBO_MULT_EN defined: multiplier rule as above.
- Undefined: mult fixed at 1, so every hit adds PTS_PER_HIT. combo and max_combo are still tracked.

Test Plan:
- Reset and start: Reset_n low, then keycode=8'h2C -> running=1, score=0, combo=0, score_bcd=16'h0000.
- Single hit: hit[39] 0->1 and held -> after ≤43 cycles score=10, combo=1; score_bcd=16'h0010 within a further 15 cycles. A held level gives no further points.
- Combo multiplier (macro on): 12 sequential hits on lanes 0..11 -> score=10*10+2*20=140, combo=12, max_combo=12. Then a miss on lane 12 -> combo=0, max_combo=12, score=140.
- Simultaneous events: hit[3] and miss[3] rise in the same cycle, plus hit[5] -> exactly 2 hits applied, combo=2, no reset of combo. An edge arriving on lane i in the cycle the scanner clears lane i is still counted on the next pass.
- Saturation: preload by 1000 hits (macro on) -> score=9999, score_bcd=16'h9999, combo=999.
- Control keys: in RUN press 8'h29 -> running=0 and further hits ignored. 8'h01 -> IDLE with score retained. 8'h2C -> score=0. Reset_n pulse mid-BCD conversion -> score_bcd=0 immediately.
